// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared owner IDs and memory message layouts for the memory arbiter.
// Message layouts match the 32-bit address / 32-bit data request and response formats.
package riscv_mem_arbiter_pkg;

  localparam int ID_SZ = 2;

  typedef enum logic [ID_SZ-1:0] {
    ID_IMEM0 = 2'd0,
    ID_IMEM1 = 2'd1,
    ID_DMEM  = 2'd2
  } owner_id_t;

  // 67-bit request: rw, addr, len, data
  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_t;

  // 35-bit response: rw, len, data
  typedef struct packed {
    logic        rw;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_t;

endpackage

// File: rtl/riscv_mem_arbiter_tagq.sv
// In-order owner-ID queue; push/pop take effect on the clock edge, head_id is combinational.
// Backpressure: full/empty are registered-state views; push when full or pop when empty is ignored.
module riscv_mem_arbiter_tagq
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  owner_id_t push_id,
  input  logic      pop,
  output owner_id_t head_id,
  output logic      empty,
  output logic      full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  owner_id_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Three-way memory arbiter (dmem fixed priority, imem0/imem1 round robin), 0-cycle grant and response steering.
// Stalls requesters when memreq_rdy is low or MAX_OUTST tags are in flight; optional RISCV_MEM_ARB_PERF_EN stall counters.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  mem_req_t         req0_msg,
  input  logic             req0_val,
  output logic             req0_rdy,
  input  mem_req_t         req1_msg,
  input  logic             req1_val,
  output logic             req1_rdy,
  input  mem_req_t         req2_msg,
  input  logic             req2_val,
  output logic             req2_rdy,
  output mem_resp_t        resp0_msg,
  output logic             resp0_val,
  output mem_resp_t        resp1_msg,
  output logic             resp1_val,
  output mem_resp_t        resp2_msg,
  output logic             resp2_val,
  output mem_req_t         memreq_msg,
  output logic             memreq_val,
  input  logic             memreq_rdy,
  input  mem_resp_t        memresp_msg,
  input  logic             memresp_val,
  output logic             err_orphan,
  output logic [CNT_W-1:0] stall_cnt0,
  output logic [CNT_W-1:0] stall_cnt1,
  output logic [CNT_W-1:0] stall_cnt2
);

  owner_id_t rr_ptr;
  owner_id_t gnt_id;
  owner_id_t head_id;
  logic [2:0] gnt;
  logic       q_empty;
  logic       q_full;
  logic       accept;
  logic       pop;

  always_comb begin
    gnt = 3'b000;
    if (req2_val)                 gnt = 3'b100;
    else if (rr_ptr == ID_IMEM0)  gnt = req0_val ? 3'b001 : (req1_val ? 3'b010 : 3'b000);
    else                          gnt = req1_val ? 3'b010 : (req0_val ? 3'b001 : 3'b000);
  end

  assign gnt_id     = gnt[2] ? ID_DMEM : (gnt[1] ? ID_IMEM1 : ID_IMEM0);
  assign memreq_msg = gnt[2] ? req2_msg : (gnt[1] ? req1_msg : req0_msg);
  assign memreq_val = reset & (req0_val | req1_val | req2_val) & ~q_full;
  assign req0_rdy   = reset & gnt[0] & memreq_rdy & ~q_full;
  assign req1_rdy   = reset & gnt[1] & memreq_rdy & ~q_full;
  assign req2_rdy   = reset & gnt[2] & memreq_rdy & ~q_full;
  assign accept     = memreq_val & memreq_rdy;
  assign pop        = reset & memresp_val & ~q_empty;

  assign resp0_val = pop & (head_id == ID_IMEM0);
  assign resp1_val = pop & (head_id == ID_IMEM1);
  assign resp2_val = pop & (head_id == ID_DMEM);
  assign resp0_msg = memresp_msg;
  assign resp1_msg = memresp_msg;
  assign resp2_msg = memresp_msg;

  riscv_mem_arbiter_tagq #(.DEPTH(MAX_OUTST)) u_tagq (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .push_id (gnt_id),
    .pop     (pop),
    .head_id (head_id),
    .empty   (q_empty),
    .full    (q_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= ID_IMEM0;
      err_orphan <= 1'b0;
    end else begin
      if (accept && !gnt[2]) rr_ptr <= gnt[0] ? ID_IMEM1 : ID_IMEM0;
      if (memresp_val && q_empty) err_orphan <= 1'b1;
    end
  end

`ifdef RISCV_MEM_ARB_PERF_EN
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       vals;
  logic [2:0]       rdys;

  assign vals = {req2_val, req1_val, req0_val};
  assign rdys = {req2_rdy, req1_rdy, req0_rdy};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (vals[i] && !rdys[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

  assign stall_cnt0 = cnt[0];
  assign stall_cnt1 = cnt[1];
  assign stall_cnt2 = cnt[2];
`else
  assign stall_cnt0 = '0;
  assign stall_cnt1 = '0;
  assign stall_cnt2 = '0;
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: reset, contention, full, push/pop overlap, orphan, stall counters.
module tb_riscv_mem_arbiter;
  import riscv_mem_arbiter_pkg::*;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  mem_req_t  req0_msg, req1_msg, req2_msg, memreq_msg;
  logic      req0_val, req1_val, req2_val, req0_rdy, req1_rdy, req2_rdy;
  mem_resp_t resp0_msg, resp1_msg, resp2_msg, memresp_msg;
  logic      resp0_val, resp1_val, resp2_val;
  logic      memreq_val, memreq_rdy, memresp_val, err_orphan;
  logic [CNT_W-1:0] stall_cnt0, stall_cnt1, stall_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.MAX_OUTST(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
    .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
    .req2_msg(req2_msg), .req2_val(req2_val), .req2_rdy(req2_rdy),
    .resp0_msg(resp0_msg), .resp0_val(resp0_val),
    .resp1_msg(resp1_msg), .resp1_val(resp1_val),
    .resp2_msg(resp2_msg), .resp2_val(resp2_val),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val),
    .err_orphan(err_orphan),
    .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1), .stall_cnt2(stall_cnt2)
  );

  task automatic idle_inputs();
    req0_val = 0; req1_val = 0; req2_val = 0;
    memreq_rdy = 0; memresp_val = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    reset = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    req0_msg = '{rw: 1'b0, addr: 32'h0000_1000, len: 2'd0, data: 32'h0};
    req1_msg = '{rw: 1'b0, addr: 32'h0000_1004, len: 2'd0, data: 32'h0};
    req2_msg = '{rw: 1'b1, addr: 32'h0000_8000, len: 2'd0, data: 32'hDEAD_BEEF};
    memresp_msg = '{rw: 1'b0, len: 2'd0, data: 32'h0};
    reset = 0;
    req0_val = 1; req1_val = 1; req2_val = 1; memreq_rdy = 1; memresp_val = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (memreq_val !== 1'b0) begin failures++; $display("FAIL reset_memreq_val got=%b exp=0", memreq_val); end
    checks++; if ({req2_rdy, req1_rdy, req0_rdy} !== 3'b000) begin failures++; $display("FAIL reset_rdy got=%b exp=000", {req2_rdy, req1_rdy, req0_rdy}); end
    checks++; if ({resp2_val, resp1_val, resp0_val} !== 3'b000) begin failures++; $display("FAIL reset_resp_val got=%b exp=000", {resp2_val, resp1_val, resp0_val}); end
    checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL reset_err_orphan got=%b exp=0", err_orphan); end
    @(negedge clk);
    reset = 1; memreq_rdy = 0; memresp_val = 0;
    #1;
    checks++; if (memreq_val !== 1'b1) begin failures++; $display("FAIL release_memreq_val got=%b exp=1", memreq_val); end
    checks++; if (memreq_msg !== req2_msg) begin failures++; $display("FAIL release_dmem_first got=%h exp=%h", memreq_msg, req2_msg); end
    checks++; if (req2_rdy !== 1'b0) begin failures++; $display("FAIL release_rdy_needs_memrdy got=%b exp=0", req2_rdy); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_contention();
    mem_resp_t r [3];
    logic [2:0] exp_vec [3];
    r[0] = '{rw: 1'b1, len: 2'd0, data: 32'h0};
    r[1] = '{rw: 1'b0, len: 2'd0, data: 32'h1111_0000};
    r[2] = '{rw: 1'b0, len: 2'd0, data: 32'h2222_0004};
    exp_vec[0] = 3'b100; exp_vec[1] = 3'b001; exp_vec[2] = 3'b010;
    @(negedge clk);
    req0_val = 1; req1_val = 1; req2_val = 1; memreq_rdy = 1;
    #1;
    checks++; if ({req2_rdy, req1_rdy, req0_rdy} !== 3'b100) begin failures++; $display("FAIL cont_grant_dmem got=%b exp=100", {req2_rdy, req1_rdy, req0_rdy}); end
    checks++; if (memreq_msg !== req2_msg) begin failures++; $display("FAIL cont_msg_dmem got=%h exp=%h", memreq_msg, req2_msg); end
    @(negedge clk);
    req2_val = 0;
    #1;
    checks++; if ({req2_rdy, req1_rdy, req0_rdy} !== 3'b001) begin failures++; $display("FAIL cont_grant_imem0 got=%b exp=001", {req2_rdy, req1_rdy, req0_rdy}); end
    checks++; if (memreq_msg !== req0_msg) begin failures++; $display("FAIL cont_msg_imem0 got=%h exp=%h", memreq_msg, req0_msg); end
    @(negedge clk);
    #1;
    checks++; if ({req2_rdy, req1_rdy, req0_rdy} !== 3'b010) begin failures++; $display("FAIL cont_grant_imem1 got=%b exp=010", {req2_rdy, req1_rdy, req0_rdy}); end
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      memresp_val = 1; memresp_msg = r[i];
      #1;
      checks++; if ({resp2_val, resp1_val, resp0_val} !== exp_vec[i]) begin failures++; $display("FAIL cont_resp_route%0d got=%b exp=%b", i, {resp2_val, resp1_val, resp0_val}, exp_vec[i]); end
      checks++; if ((i == 0 && resp2_msg !== r[i]) || (i == 1 && resp0_msg !== r[i]) || (i == 2 && resp1_msg !== r[i])) begin
        failures++; $display("FAIL cont_resp_msg%0d exp=%h", i, r[i]);
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    checks++; if (dut.u_tagq.count !== 3'd0) begin failures++; $display("FAIL cont_drained_count got=%0d exp=0", dut.u_tagq.count); end
  endtask

  task automatic test_full();
    @(negedge clk);
    req0_val = 1; memreq_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req0_rdy !== 1'b1) begin failures++; $display("FAIL full_accept%0d got=%b exp=1", i, req0_rdy); end
      @(negedge clk);
    end
    #1;
    checks++; if (memreq_val !== 1'b0) begin failures++; $display("FAIL full_memreq_val got=%b exp=0", memreq_val); end
    checks++; if (req0_rdy !== 1'b0) begin failures++; $display("FAIL full_rdy got=%b exp=0", req0_rdy); end
    memresp_val = 1;
    #1;
    checks++; if (resp0_val !== 1'b1) begin failures++; $display("FAIL full_pop_resp0 got=%b exp=1", resp0_val); end
    checks++; if (memreq_val !== 1'b0) begin failures++; $display("FAIL full_no_bypass got=%b exp=0", memreq_val); end
    @(negedge clk);
    memresp_val = 0;
    #1;
    checks++; if (memreq_val !== 1'b1 || req0_rdy !== 1'b1) begin failures++; $display("FAIL full_reaccept got=%b%b exp=11", memreq_val, req0_rdy); end
    @(negedge clk);
    req0_val = 0; memreq_rdy = 0;
    #1;
    checks++; if (dut.u_tagq.count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", dut.u_tagq.count); end
    for (int i = 0; i < 4; i++) begin
      memresp_val = 1;
      #1;
      checks++; if ({resp2_val, resp1_val, resp0_val} !== 3'b001) begin failures++; $display("FAIL full_drain%0d got=%b exp=001", i, {resp2_val, resp1_val, resp0_val}); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    int pat [10] = '{2, 0, 1, 1, 2, 0, 2, 1, 0, 2};
    int exp_q [$];
    int h;
    @(negedge clk);
    memreq_rdy = 1;
    req0_val = 1; exp_q.push_back(0);
    @(negedge clk);
    req0_val = 0; req1_val = 1; exp_q.push_back(1);
    @(negedge clk);
    req1_val = 0;
    #1;
    checks++; if (dut.u_tagq.count !== 3'd2) begin failures++; $display("FAIL sim_prefill_count got=%0d exp=2", dut.u_tagq.count); end
    for (int i = 0; i < 10; i++) begin
      req0_val = (pat[i] == 0); req1_val = (pat[i] == 1); req2_val = (pat[i] == 2);
      memresp_val = 1;
      memresp_msg = '{rw: 1'b0, len: 2'd0, data: 32'(i)};
      h = exp_q.pop_front();
      exp_q.push_back(pat[i]);
      #1;
      checks++; if ({resp2_val, resp1_val, resp0_val} !== (3'b001 << h)) begin failures++; $display("FAIL sim_route%0d got=%b exp=%b", i, {resp2_val, resp1_val, resp0_val}, 3'b001 << h); end
      checks++; if (memreq_val !== 1'b1) begin failures++; $display("FAIL sim_push%0d got=%b exp=1", i, memreq_val); end
      @(negedge clk);
      #1;
      checks++; if (dut.u_tagq.count !== 3'd2) begin failures++; $display("FAIL sim_count%0d got=%0d exp=2", i, dut.u_tagq.count); end
    end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      memresp_val = 1;
      h = exp_q.pop_front();
      #1;
      checks++; if ({resp2_val, resp1_val, resp0_val} !== (3'b001 << h)) begin failures++; $display("FAIL sim_drain%0d got=%b exp=%b", i, {resp2_val, resp1_val, resp0_val}, 3'b001 << h); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_orphan();
    @(negedge clk);
    #1;
    checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL orphan_pre got=%b exp=0", err_orphan); end
    memresp_val = 1;
    #1;
    checks++; if ({resp2_val, resp1_val, resp0_val} !== 3'b000) begin failures++; $display("FAIL orphan_no_resp got=%b exp=000", {resp2_val, resp1_val, resp0_val}); end
    @(negedge clk);
    memresp_val = 0;
    #1;
    checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_set got=%b exp=1", err_orphan); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
    pulse_reset();
    #1;
    checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL orphan_cleared got=%b exp=0", err_orphan); end
  endtask

  task automatic test_perf();
    logic [CNT_W-1:0] exp1;
`ifdef RISCV_MEM_ARB_PERF_EN
    exp1 = 16'd7;
`else
    exp1 = 16'd0;
`endif
    pulse_reset();
    req1_val = 1; memreq_rdy = 0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    req1_val = 0;
    #1;
    checks++; if (stall_cnt1 !== exp1) begin failures++; $display("FAIL perf_stall_cnt1 got=%0d exp=%0d", stall_cnt1, exp1); end
    checks++; if (stall_cnt0 !== 16'd0) begin failures++; $display("FAIL perf_stall_cnt0 got=%0d exp=0", stall_cnt0); end
    checks++; if (stall_cnt2 !== 16'd0) begin failures++; $display("FAIL perf_stall_cnt2 got=%0d exp=0", stall_cnt2); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_contention();
    test_full();
    test_simultaneous();
    test_orphan();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
